zkbdmus_spirx: RTL and testbench

//  SPI-slave front end that receives keyboard-matrix, mouse and kempston-joystick data from the AVR.
//  It produces the 40-bit key vector with its strobe, and the 8-bit mouse/joystick byte with
//  per-register strobes, in the fclk domain. These outputs drive the zkbdmus register/port mux.

---
 rtl/zkbdmus_spirx_pkg.sv | 51 +++++
 rtl/zspi_sync_edge.sv | 48 ++++
 rtl/zkbdmus_spirx.sv | 177 +++++++++++++++++
 tb/tb_zkbdmus_spirx.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zkbdmus_spirx_pkg.sv
// Shared definitions for the zkbdmus SPI receiver.
// Holds the default AVR command codes (mirrored by the AVR firmware), the FSM
// state encoding, the frame target encoding and the command decoder.
package zkbdmus_spirx_pkg;

  localparam logic [7:0] CMD_KBD_DEF    = 8'h10;
  localparam logic [7:0] CMD_MUSX_DEF   = 8'h20;
  localparam logic [7:0] CMD_MUSY_DEF   = 8'h21;
  localparam logic [7:0] CMD_MUSBTN_DEF = 8'h22;
  localparam logic [7:0] CMD_KJ_DEF     = 8'h23;

  // Index of the last data bit within a frame (bit counter runs 0..N-1)
  localparam logic [5:0] KBD_LAST_BIT = 6'd39;
  localparam logic [5:0] BYTE_LAST_BIT = 6'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_SKIP = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    TGT_NONE   = 3'd0,
    TGT_KBD    = 3'd1,
    TGT_MUSX   = 3'd2,
    TGT_MUSY   = 3'd3,
    TGT_MUSBTN = 3'd4,
    TGT_KJ     = 3'd5
  } tgt_t;

  // Map a received command byte onto the register it addresses.
  function automatic tgt_t decode_cmd(
    input logic [7:0] cmd,
    input logic [7:0] c_kbd,
    input logic [7:0] c_musx,
    input logic [7:0] c_musy,
    input logic [7:0] c_musbtn,
    input logic [7:0] c_kj
  );
    tgt_t t;
    t = TGT_NONE;
    if (cmd == c_kbd)         t = TGT_KBD;
    else if (cmd == c_musx)   t = TGT_MUSX;
    else if (cmd == c_musy)   t = TGT_MUSY;
    else if (cmd == c_musbtn) t = TGT_MUSBTN;
    else if (cmd == c_kj)     t = TGT_KJ;
    return t;
  endfunction

endpackage

// File: rtl/zspi_sync_edge.sv
// Synchroniser for the asynchronous AVR SPI pins into the fclk domain.
// Ports:
//   i_clk       fclk
//   i_rst_n     active-low reset (asynchronous assert)
//   i_spick     raw SPI clock
//   i_spics_n   raw chip select, active low
//   i_spido     raw MOSI
//   o_ck_rise   one-cycle pulse on a synchronised spick rising edge
//   o_cs_n      synchronised chip select level
//   o_do        synchronised MOSI, from the same stage as spick
module zspi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_spick,
  input  logic i_spics_n,
  input  logic i_spido,
  output logic o_ck_rise,
  output logic o_cs_n,
  output logic o_do
);

  logic [SYNC_STAGES-1:0] r_ck;
  logic [SYNC_STAGES-1:0] r_cs;
  logic [SYNC_STAGES-1:0] r_do;
  logic                   r_ck_prev;

  // Chip select resets to "deselected" so no frame can start inside reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ck      <= '0;
      r_cs      <= '1;
      r_do      <= '0;
      r_ck_prev <= 1'b0;
    end else begin
      r_ck      <= {r_ck[SYNC_STAGES-2:0], i_spick};
      r_cs      <= {r_cs[SYNC_STAGES-2:0], i_spics_n};
      r_do      <= {r_do[SYNC_STAGES-2:0], i_spido};
      r_ck_prev <= r_ck[SYNC_STAGES-1];
    end
  end

  assign o_ck_rise = r_ck[SYNC_STAGES-1] & ~r_ck_prev;
  assign o_cs_n    = r_cs[SYNC_STAGES-1];
  assign o_do      = r_do[SYNC_STAGES-1];

endmodule

// File: rtl/zkbdmus_spirx.sv
// SPI-slave receiver for keyboard matrix, mouse and kempston joystick data
// sent by the AVR. Write-only: there is no MISO path.
// Ports:
//   fclk        system clock (only clock)
//   rst_n       asynchronous active-low reset, released synchronously
//   spics_n     AVR chip select, active low, asynchronous
//   spick       AVR SPI clock, mode 0, asynchronous
//   spido       AVR MOSI, MSB first, asynchronous
//   kbd_out     40-bit key vector, first received bit in [39]
//   kbd_stb     one-cycle pulse, kbd_out valid in the same cycle
//   mus_out     mouse/joystick byte shared by the four byte commands
//   mus_xstb    one-cycle pulse: mus_out is mouse X
//   mus_ystb    one-cycle pulse: mus_out is mouse Y
//   mus_btnstb  one-cycle pulse: mus_out is mouse buttons
//   kj_stb      one-cycle pulse: mus_out is joystick
module zkbdmus_spirx
  import zkbdmus_spirx_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CMD_KBD     = CMD_KBD_DEF,
  parameter logic [7:0] CMD_MUSX    = CMD_MUSX_DEF,
  parameter logic [7:0] CMD_MUSY    = CMD_MUSY_DEF,
  parameter logic [7:0] CMD_MUSBTN  = CMD_MUSBTN_DEF,
  parameter logic [7:0] CMD_KJ      = CMD_KJ_DEF
) (
  input  logic        fclk,
  input  logic        rst_n,
  input  logic        spics_n,
  input  logic        spick,
  input  logic        spido,
  output logic [39:0] kbd_out,
  output logic        kbd_stb,
  output logic [7:0]  mus_out,
  output logic        mus_xstb,
  output logic        mus_ystb,
  output logic        mus_btnstb,
  output logic        kj_stb
);

  logic [1:0]  r_rst_sync;
  logic        w_rst_n;
  logic        w_rise;
  logic        w_cs_n;
  logic        w_do;

  state_t      r_state;
  state_t      w_state_nxt;
  tgt_t        r_tgt;
  tgt_t        w_cmd_tgt;
  logic [5:0]  r_bitcnt;
  logic [39:0] r_shift;
  logic [39:0] w_shift_nxt;
  logic [5:0]  w_last_idx;
  logic        w_cmd_done;
  logic        w_data_done;

  // Reset asserts immediately but is released on an fclk edge.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  zspi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk    (fclk),
    .i_rst_n  (w_rst_n),
    .i_spick  (spick),
    .i_spics_n(spics_n),
    .i_spido  (spido),
    .o_ck_rise(w_rise),
    .o_cs_n   (w_cs_n),
    .o_do     (w_do)
  );

  assign w_shift_nxt = {r_shift[38:0], w_do};
  assign w_cmd_tgt   = decode_cmd(w_shift_nxt[7:0], CMD_KBD, CMD_MUSX,
                                  CMD_MUSY, CMD_MUSBTN, CMD_KJ);
  assign w_last_idx  = (r_tgt == TGT_KBD) ? KBD_LAST_BIT : BYTE_LAST_BIT;

  // A deselected chip select masks both events, so a CS rise coinciding with
  // the last bit drops the frame.
  assign w_cmd_done  = !w_cs_n && w_rise && (r_state == ST_CMD) &&
                       (r_bitcnt == BYTE_LAST_BIT);
  assign w_data_done = !w_cs_n && w_rise && (r_state == ST_DATA) &&
                       (r_bitcnt == w_last_idx);

  always_ff @(posedge fclk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_cs_n) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_CMD;
        ST_CMD:  if (w_cmd_done) w_state_nxt = (w_cmd_tgt == TGT_NONE) ? ST_SKIP : ST_DATA;
        ST_DATA: if (w_data_done) w_state_nxt = ST_SKIP;
        default: w_state_nxt = ST_SKIP;
      endcase
    end
  end

  // Bit counter, shift register and frame target
  always_ff @(posedge fclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_tgt    <= TGT_NONE;
    end else if (w_cs_n) begin
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_tgt    <= TGT_NONE;
    end else if (w_rise && (r_state == ST_CMD || r_state == ST_DATA)) begin
      if (w_cmd_done) begin
        r_bitcnt <= '0;
        r_shift  <= '0;
        r_tgt    <= w_cmd_tgt;
      end else if (w_data_done) begin
        r_bitcnt <= '0;
        r_shift  <= '0;
      end else begin
        r_bitcnt <= r_bitcnt + 6'd1;
        r_shift  <= w_shift_nxt;
      end
    end
  end

  // Output registers and strobes: written only when a frame completes
  always_ff @(posedge fclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      kbd_out    <= '0;
      kbd_stb    <= 1'b0;
      mus_out    <= '0;
      mus_xstb   <= 1'b0;
      mus_ystb   <= 1'b0;
      mus_btnstb <= 1'b0;
      kj_stb     <= 1'b0;
    end else begin
      kbd_stb    <= 1'b0;
      mus_xstb   <= 1'b0;
      mus_ystb   <= 1'b0;
      mus_btnstb <= 1'b0;
      kj_stb     <= 1'b0;
      if (w_data_done) begin
        case (r_tgt)
          TGT_KBD: begin
            kbd_out <= w_shift_nxt;
            kbd_stb <= 1'b1;
          end
          TGT_MUSX: begin
            mus_out  <= w_shift_nxt[7:0];
            mus_xstb <= 1'b1;
          end
          TGT_MUSY: begin
            mus_out  <= w_shift_nxt[7:0];
            mus_ystb <= 1'b1;
          end
          TGT_MUSBTN: begin
            mus_out    <= w_shift_nxt[7:0];
            mus_btnstb <= 1'b1;
          end
          TGT_KJ: begin
            mus_out <= w_shift_nxt[7:0];
            kj_stb  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_zkbdmus_spirx.sv
module tb_zkbdmus_spirx;

  localparam int K_KBD = 0;
  localparam int K_X   = 1;
  localparam int K_Y   = 2;
  localparam int K_BTN = 3;
  localparam int K_KJ  = 4;

  logic        fclk = 1'b0;
  logic        rst_n = 1'b1;
  logic        spics_n = 1'b1;
  logic        spick = 1'b0;
  logic        spido = 1'b0;
  logic [39:0] kbd_out;
  logic        kbd_stb;
  logic [7:0]  mus_out;
  logic        mus_xstb;
  logic        mus_ystb;
  logic        mus_btnstb;
  logic        kj_stb;

  typedef struct {
    int          kind;
    logic [39:0] data;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          g_h = 4;
  logic [39:0] exp_kbd = '0;
  logic [7:0]  exp_mus = '0;

  int          m_n;
  int          m_kind;
  logic [39:0] m_data;
  exp_t        m_e;

  zkbdmus_spirx #(.SYNC_STAGES(2)) dut (
    .fclk      (fclk),
    .rst_n     (rst_n),
    .spics_n   (spics_n),
    .spick     (spick),
    .spido     (spido),
    .kbd_out   (kbd_out),
    .kbd_stb   (kbd_stb),
    .mus_out   (mus_out),
    .mus_xstb  (mus_xstb),
    .mus_ystb  (mus_ystb),
    .mus_btnstb(mus_btnstb),
    .kj_stb    (kj_stb)
  );

  always #5 fclk = ~fclk;

  // Scoreboard monitor: every strobe cycle pops one expected frame result.
  always @(negedge fclk) begin
    if (rst_n) begin
      m_n = int'(kbd_stb) + int'(mus_xstb) + int'(mus_ystb) + int'(mus_btnstb) + int'(kj_stb);
      if (m_n != 0) begin
        checks++;
        m_kind = kbd_stb ? K_KBD : mus_xstb ? K_X : mus_ystb ? K_Y : mus_btnstb ? K_BTN : K_KJ;
        m_data = kbd_stb ? kbd_out : {32'h0, mus_out};
        if (m_n > 1) begin
          errors++;
          $display("FAIL strobe_count: %0d strobes at once, required 1", m_n);
        end else if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: kind %0d data %h, required no strobe", m_kind, m_data);
        end else begin
          m_e = q.pop_front();
          if (m_kind !== m_e.kind || m_data !== m_e.data) begin
            errors++;
            $display("FAIL frame_result: kind %0d data %h, required kind %0d data %h",
                     m_kind, m_data, m_e.kind, m_e.data);
          end
        end
      end
    end
  end

  function automatic logic [7:0] cmd_code(input int kind);
    case (kind)
      K_KBD:   return 8'h10;
      K_X:     return 8'h20;
      K_Y:     return 8'h21;
      K_BTN:   return 8'h22;
      default: return 8'h23;
    endcase
  endfunction

  task automatic push_exp(input int kind, input logic [39:0] d);
    exp_t e;
    e.kind = kind;
    e.data = (kind == K_KBD) ? d : {32'h0, d[7:0]};
    q.push_back(e);
    if (kind == K_KBD) exp_kbd = d;
    else exp_mus = d[7:0];
  endtask

  task automatic begin_frame();
    @(posedge fclk);
    #($urandom_range(1, 9));
    spics_n = 1'b0;
    #(g_h * 10);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      spido = b[i];
      #(g_h * 10);
      spick = 1'b1;
      #(g_h * 10);
      spick = 1'b0;
    end
  endtask

  task automatic end_frame(input int gap);
    #(g_h * 10);
    spics_n = 1'b1;
    #(gap * 10);
  endtask

  task automatic send_cmd_frame(input int kind, input logic [39:0] d, input int gap);
    push_exp(kind, d);
    begin_frame();
    send_byte(cmd_code(kind));
    if (kind == K_KBD) begin
      for (int i = 4; i >= 0; i--) send_byte(d[i*8 +: 8]);
    end else begin
      send_byte(d[7:0]);
    end
    end_frame(gap);
  endtask

  task automatic settle();
    #(20 * 10);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge fclk);
    checks++;
    if (kbd_out !== 40'h0) begin
      errors++;
      $display("FAIL reset_kbd_out: got %h, required 0", kbd_out);
    end
    checks++;
    if (mus_out !== 8'h0) begin
      errors++;
      $display("FAIL reset_mus_out: got %h, required 0", mus_out);
    end
    checks++;
    if ({kbd_stb, mus_xstb, mus_ystb, mus_btnstb, kj_stb} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b, required 00000",
               {kbd_stb, mus_xstb, mus_ystb, mus_btnstb, kj_stb});
    end
    #3 rst_n = 1'b1;
    repeat (5) @(posedge fclk);
  endtask

  task automatic test_kbd();
    send_cmd_frame(K_KBD, 40'h01_0204_0880, 10);
    settle();
    checks++;
    if (q.size() !== 0) begin
      errors++;
      $display("FAIL kbd_pending: %0d results outstanding, required 0", q.size());
    end
    checks++;
    if (kbd_out !== 40'h01_0204_0880) begin
      errors++;
      $display("FAIL kbd_hold: got %h, required 0102040880", kbd_out);
    end
  endtask

  task automatic test_reset_midframe();
    begin_frame();
    send_byte(8'h10);
    send_byte(8'h01);
    rst_n = 1'b0;
    exp_kbd = '0;
    exp_mus = '0;
    send_byte(8'h02);
    @(negedge fclk);
    checks++;
    if (kbd_out !== 40'h0 || mus_out !== 8'h0) begin
      errors++;
      $display("FAIL midreset_outputs: kbd %h mus %h, required 0 0", kbd_out, mus_out);
    end
    checks++;
    if ({kbd_stb, mus_xstb, mus_ystb, mus_btnstb, kj_stb} !== 5'b0) begin
      errors++;
      $display("FAIL midreset_strobes: got %b, required 00000",
               {kbd_stb, mus_xstb, mus_ystb, mus_btnstb, kj_stb});
    end
    #3 rst_n = 1'b1;
    send_byte(8'h04);
    send_byte(8'h08);
    end_frame(10);
    settle();
    checks++;
    if (kbd_out !== 40'h0) begin
      errors++;
      $display("FAIL midreset_partial: kbd %h, required 0", kbd_out);
    end
    send_cmd_frame(K_KBD, 40'h01_0204_0880, 10);
    settle();
    checks++;
    if (q.size() !== 0) begin
      errors++;
      $display("FAIL midreset_recover: %0d results outstanding, required 0", q.size());
    end
  endtask

  task automatic test_mouse();
    send_cmd_frame(K_X,   40'h5A, 10);
    send_cmd_frame(K_Y,   40'hA5, 10);
    send_cmd_frame(K_BTN, 40'h07, 10);
    send_cmd_frame(K_KJ,  40'h1F, 10);
    settle();
    checks++;
    if (q.size() !== 0) begin
      errors++;
      $display("FAIL mouse_pending: %0d results outstanding, required 0", q.size());
    end
    checks++;
    if (mus_out !== 8'h1F) begin
      errors++;
      $display("FAIL mouse_hold: got %h, required 1f", mus_out);
    end
  endtask

  task automatic test_abort();
    begin_frame();
    send_byte(8'h10);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    end_frame(10);
    settle();
    checks++;
    if (kbd_out !== exp_kbd) begin
      errors++;
      $display("FAIL abort_kbd: got %h, required %h", kbd_out, exp_kbd);
    end
    send_cmd_frame(K_KBD, 40'hFF_FFFF_FFFF, 10);
    settle();
    checks++;
    if (q.size() !== 0 || kbd_out !== 40'hFF_FFFF_FFFF) begin
      errors++;
      $display("FAIL abort_recover: kbd %h pending %0d, required ffffffffff pending 0",
               kbd_out, q.size());
    end
  endtask

  task automatic test_unknown_extra();
    begin_frame();
    send_byte(8'h33);
    send_byte(8'hAA);
    end_frame(10);
    settle();
    checks++;
    if (mus_out !== exp_mus || kbd_out !== exp_kbd) begin
      errors++;
      $display("FAIL unknown_cmd: kbd %h mus %h, required %h %h", kbd_out, mus_out, exp_kbd, exp_mus);
    end
    push_exp(K_X, 40'h11);
    begin_frame();
    send_byte(8'h20);
    send_byte(8'h11);
    send_byte(8'h22);
    end_frame(10);
    settle();
    checks++;
    if (q.size() !== 0 || mus_out !== 8'h11) begin
      errors++;
      $display("FAIL extra_byte: mus %h pending %0d, required 11 pending 0", mus_out, q.size());
    end
  endtask

  task automatic test_cs_high_toggle();
    @(posedge fclk);
    #4;
    send_byte(8'h20);
    send_byte(8'h55);
    settle();
    checks++;
    if (mus_out !== exp_mus) begin
      errors++;
      $display("FAIL cs_high_toggle: mus %h, required %h", mus_out, exp_mus);
    end
    send_cmd_frame(K_Y, 40'h3C, 10);
    settle();
    checks++;
    if (q.size() !== 0) begin
      errors++;
      $display("FAIL cs_high_recover: %0d results outstanding, required 0", q.size());
    end
  endtask

  task automatic test_cs_wins();
    logic [7:0] last;
    last = 8'h55;
    begin_frame();
    send_byte(8'h10);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    for (int i = 7; i >= 1; i--) begin
      spido = last[i];
      #(g_h * 10);
      spick = 1'b1;
      #(g_h * 10);
      spick = 1'b0;
    end
    spido = last[0];
    #(g_h * 10);
    spick = 1'b1;
    spics_n = 1'b1;
    #(g_h * 10);
    spick = 1'b0;
    settle();
    checks++;
    if (kbd_out !== exp_kbd) begin
      errors++;
      $display("FAIL cs_wins: kbd %h, required %h", kbd_out, exp_kbd);
    end
  endtask

  task automatic test_min_width_random();
    logic [63:0] r;
    int kind;
    g_h = 3;
    for (int n = 0; n < 10; n++) begin
      kind = $urandom_range(0, 4);
      r = {$urandom, $urandom};
      send_cmd_frame(kind, r[39:0], 5);
    end
    settle();
    checks++;
    if (q.size() !== 0) begin
      errors++;
      $display("FAIL min_width_random: %0d results outstanding, required 0", q.size());
    end
  endtask

  task automatic test_back_to_back();
    g_h = 3;
    send_cmd_frame(K_KBD, 40'hA5_5AC3_3C96, 3);
    send_cmd_frame(K_BTN, 40'h81, 3);
    send_cmd_frame(K_KJ,  40'h42, 3);
    send_cmd_frame(K_KBD, 40'h12_3456_789A, 3);
    settle();
    checks++;
    if (q.size() !== 0) begin
      errors++;
      $display("FAIL back_to_back: %0d results outstanding, required 0", q.size());
    end
    checks++;
    if (kbd_out !== 40'h12_3456_789A || mus_out !== 8'h42) begin
      errors++;
      $display("FAIL back_to_back_hold: kbd %h mus %h, required 123456789a 42", kbd_out, mus_out);
    end
    g_h = 4;
  endtask

  initial begin
    test_reset();
    test_kbd();
    test_reset_midframe();
    test_mouse();
    test_abort();
    test_unknown_extra();
    test_cs_high_toggle();
    test_cs_wins();
    test_min_width_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
